// File: rtl/four_bit_adder.sv
// rtl/four_bit_adder.sv - ripple-carry adder with combinational and registered results
// Optional: define FOUR_BIT_ADDER_OVERFLOW_EN to add overflow / overflow_q.
module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
  output logic             overflow,
  output logic             overflow_q,
`endif
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q
);

  logic [WIDTH-1:0] sum_c;
  logic             carry;
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
  logic             carry_msb_in;
`endif

  // Full-adder chain; carry walks from bit 0 upward, one cell per bit.
  always_comb begin
    sum_c = '0;
    carry = carry_in;
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
    carry_msb_in = carry_in;
`endif
    for (int i = 0; i < WIDTH; i++) begin
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
      carry_msb_in = carry;
`endif
      sum_c[i] = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
  end

  assign sum       = sum_c;
  assign carry_out = carry;

`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = carry ^ carry_msb_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      sum_q       <= sum_c;
      carry_out_q <= carry;
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
// tb/tb_four_bit_adder.sv - randomized and directed checks of four_bit_adder against an arithmetic model
module tb_four_bit_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic [W-1:0] sum_q;
  logic         carry_out_q;
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
  logic         overflow;
  logic         overflow_q;
`endif

  int n_compared = 0;
  int n_mismatched = 0;

  // Registered-output model: value the flops should currently hold.
  int q_val = 0;
  int q_ovf = 0;

  four_bit_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .sum         (sum),
    .carry_out   (carry_out),
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
    .overflow    (overflow),
    .overflow_q  (overflow_q),
`endif
    .sum_q       (sum_q),
    .carry_out_q (carry_out_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (a=%0d b=%0d cin=%0d t=%0t)",
               tag, got, exp, a, b, carry_in, $time);
    end
  endtask

  function automatic int signed_ovf(input int va, input int vb, input int vc);
    int sa, sb, s;
    sa = (va >= (1 << (W - 1))) ? va - (1 << W) : va;
    sb = (vb >= (1 << (W - 1))) ? vb - (1 << W) : vb;
    s  = sa + sb + vc;
    return (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
  endfunction

  task automatic drive(input int va, input int vb, input int vc);
    int total;
    @(negedge clk);
    a = va[W-1:0];
    b = vb[W-1:0];
    carry_in = vc[0];
    total = va + vb + vc;
    #1;
    check("sum", 32'(sum), total % (1 << W));
    check("carry_out", 32'(carry_out), (total >= (1 << W)) ? 1 : 0);
    check("sum_q_pre_edge", 32'(sum_q), q_val % (1 << W));
    check("carry_out_q_pre_edge", 32'(carry_out_q), (q_val >= (1 << W)) ? 1 : 0);
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
    check("overflow", 32'(overflow), signed_ovf(va, vb, vc));
    check("overflow_q_pre_edge", 32'(overflow_q), q_ovf);
`endif
    @(posedge clk);
    #1;
    q_val = total;
    q_ovf = signed_ovf(va, vb, vc);
    check("sum_q", 32'(sum_q), q_val % (1 << W));
    check("carry_out_q", 32'(carry_out_q), (q_val >= (1 << W)) ? 1 : 0);
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
    check("overflow_q", 32'(overflow_q), q_ovf);
`endif
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_sum_q", 32'(sum_q), 0);
    check("reset_carry_out_q", 32'(carry_out_q), 0);
    @(posedge clk);
    #1;
    check("reset_hold_sum_q", 32'(sum_q), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        drive(i, j, i % 2);

    drive(15, 1, 0);
    drive(15, 15, 1);
    drive(0, 0, 0);
    drive(15, 0, 1);
    drive(3, 4, 0);
    drive(7, 1, 0);
    drive(8, 8, 0);
    drive(15, 1, 1);

    // Async reset between edges while the live sum keeps showing 9.
    drive(4, 5, 0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_sum_q", 32'(sum_q), 0);
    check("async_rst_carry_out_q", 32'(carry_out_q), 0);
    check("async_rst_live_sum", 32'(sum), 9);
`ifdef FOUR_BIT_ADDER_OVERFLOW_EN
    check("async_rst_overflow_q", 32'(overflow_q), 0);
`endif
    @(posedge clk);
    #1;
    check("rst_held_sum_q", 32'(sum_q), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    q_val = 9;
    q_ovf = signed_ovf(4, 5, 0);
    check("first_capture_sum_q", 32'(sum_q), 9);
    check("first_capture_carry_out_q", 32'(carry_out_q), 0);

    for (int k = 0; k < 200; k++)
      drive(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(1, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
